// File: rtl/memory_arbiter_if.sv
// MemoryInterface: request/response bundle shared by the caches, the arbiter and the RAM.
// The master side issues address/data/enables; the slave side answers with read data and completion.
interface MemoryInterface #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic [ADDRESS_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0]    dataOut;
  logic [DATA_WIDTH-1:0]    dataIn;
  logic                     readEnabled;
  logic                     writeEnabled;
  logic                     functionComplete;

  modport master (
    output address, dataOut, readEnabled, writeEnabled,
    input  dataIn, functionComplete
  );

  modport slave (
    input  address, dataOut, readEnabled, writeEnabled,
    output dataIn, functionComplete
  );
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter giving one RAM port to two requesters, one whole transaction at a time,
// with a one-cycle RELEASE gap between grants so the RAM delay counter can reload.
module memory_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic           clock,
  input  logic           reset,
  MemoryInterface.slave  requester0,
  MemoryInterface.slave  requester1,
  MemoryInterface.master memoryInterface,
  output logic [1:0]     grant,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                   state_q;
  logic [1:0]               grant_q;
  logic                     busy_q;
  logic                     lastServed_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [DATA_WIDTH-1:0]    dataOut_q;

  logic                     req0;
  logic                     req1;
  logic                     pickOne;
  logic [1:0]               nextGrant;
  logic                     inBusy;
  logic                     ownerRead;
  logic                     ownerWrite;
  logic                     ownerReq;
  logic [ADDRESS_WIDTH-1:0] ownerAddress;
  logic [DATA_WIDTH-1:0]    ownerData;

  assign req0 = requester0.readEnabled | requester0.writeEnabled;
  assign req1 = requester1.readEnabled | requester1.writeEnabled;

  // On a tie the requester that was not served last wins.
  assign pickOne   = req1 & (~req0 | ~lastServed_q);
  assign nextGrant = pickOne ? 2'b10 : 2'b01;

  assign inBusy       = (state_q == BUSY);
  assign ownerAddress = grant_q[1] ? requester1.address      : requester0.address;
  assign ownerData    = grant_q[1] ? requester1.dataOut      : requester0.dataOut;
  assign ownerRead    = grant_q[1] ? requester1.readEnabled  : requester0.readEnabled;
  assign ownerWrite   = grant_q[1] ? requester1.writeEnabled : requester0.writeEnabled;
  assign ownerReq     = ownerRead | ownerWrite;

  // lastServed is recorded as BUSY exits, so the RELEASE-cycle arbitration already sees it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      lastServed_q <= 1'b1;
      address_q    <= '0;
      dataOut_q    <= '0;
    end else begin
      case (state_q)
        IDLE, RELEASE: begin
          if (req0 | req1) begin
            state_q <= BUSY;
            grant_q <= nextGrant;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
          end
        end
        BUSY: begin
          address_q <= ownerAddress;
          dataOut_q <= ownerData;
          if (memoryInterface.functionComplete | ~ownerReq) begin
            state_q      <= RELEASE;
            grant_q      <= 2'b00;
            busy_q       <= 1'b0;
            lastServed_q <= grant_q[1];
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= 2'b00;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign memoryInterface.address      = inBusy ? ownerAddress : address_q;
  assign memoryInterface.dataOut      = inBusy ? ownerData : dataOut_q;
  assign memoryInterface.readEnabled  = inBusy & ownerRead;
  assign memoryInterface.writeEnabled = inBusy & ownerWrite;

  assign requester0.dataIn           = memoryInterface.dataIn;
  assign requester1.dataIn           = memoryInterface.dataIn;
  assign requester0.functionComplete = memoryInterface.functionComplete & inBusy & grant_q[0];
  assign requester1.functionComplete = memoryInterface.functionComplete & inBusy & grant_q[1];

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a DELAY=4 RAM model and a scoreboard of
// expected grants and read data, consumed as the arbiter hands out grants and completions.
module tb_memory_arbiter;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int RAM_DELAY = 4;

  typedef struct {
    logic          isWrite;
    logic [DW-1:0] data;
  } expect_t;

  logic       clock;
  logic       reset;
  logic [1:0] grant;
  logic       busy;

  MemoryInterface #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) rq0 ();
  MemoryInterface #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) rq1 ();
  MemoryInterface #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) memIf ();

  memory_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock          (clock),
    .reset          (reset),
    .requester0     (rq0),
    .requester1     (rq1),
    .memoryInterface(memIf),
    .grant          (grant),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // RAM model: counter idles at DELAY-1 and completes when it reaches zero while enabled.
  logic [DW-1:0] ram [16];
  int            ramCount;

  assign memIf.functionComplete = (memIf.readEnabled | memIf.writeEnabled) && (ramCount == 0);
  assign memIf.dataIn           = ram[memIf.address[3:0]];

  initial begin
    for (int i = 0; i < 16; i++) ram[i] <= '0;
    ram[5] <= 32'hAB;
  end

  always @(posedge clock) begin
    if (memIf.readEnabled | memIf.writeEnabled)
      ramCount <= (ramCount == 0) ? RAM_DELAY - 1 : ramCount - 1;
    else
      ramCount <= RAM_DELAY - 1;
    if (memIf.writeEnabled && ramCount == 0)
      ram[memIf.address[3:0]] <= memIf.dataOut;
  end

  int         checks;
  int         errors;
  expect_t    q0[$];
  expect_t    q1[$];
  logic [1:0] grantQ[$];
  logic [1:0] prevGrant;
  logic [1:0] done;
  logic [1:0] autoRelease;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int n, input logic rd, input logic wr,
                               input logic [AW-1:0] addr, input logic [DW-1:0] data);
    if (n == 0) begin
      rq0.readEnabled = rd; rq0.writeEnabled = wr; rq0.address = addr; rq0.dataOut = data;
    end else begin
      rq1.readEnabled = rd; rq1.writeEnabled = wr; rq1.address = addr; rq1.dataOut = data;
    end
  endtask

  task automatic pushExpect(input int n, input logic isWrite, input logic [DW-1:0] data);
    expect_t e;
    e.isWrite = isWrite;
    e.data    = data;
    if (n == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic scoreRequester(input int n, input logic fc, input logic [DW-1:0] data);
    expect_t e;
    int      pending;
    if (!fc) return;
    done[n] = 1'b1;
    pending = (n == 0) ? q0.size() : q1.size();
    checks++;
    if (pending == 0) begin
      errors++;
      $error("[TB] FAIL complete%0d: observed unexpected functionComplete, expected none", n);
      return;
    end
    if (n == 0) e = q0.pop_front();
    else        e = q1.pop_front();
    if (!e.isWrite) begin
      checks--;
      checkOutput($sformatf("read%0d data", n), data, e.data);
    end
  endtask

  // Sample at the falling edge, consuming scoreboard entries for new grants and completions.
  task automatic sampleCycle();
    @(negedge clock);
    if (grant != 2'b00 && prevGrant == 2'b00) begin
      if (grantQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL grant order: observed %b expected no grant", grant);
      end else begin
        checkOutput("grant order", grant, grantQ.pop_front());
      end
    end
    prevGrant = grant;
    scoreRequester(0, rq0.functionComplete, rq0.dataIn);
    scoreRequester(1, rq1.functionComplete, rq1.dataIn);
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
    if (done[0] && autoRelease[0]) applyStimulus(0, 1'b0, 1'b0, rq0.address, rq0.dataOut);
    if (done[1] && autoRelease[1]) applyStimulus(1, 1'b0, 1'b0, rq1.address, rq1.dataOut);
    done = 2'b00;
  endtask

  task automatic runCycle();
    sampleCycle();
    nextCycle();
  endtask

  task automatic doReset();
    reset = 1'b0;
    runCycle();
    runCycle();
    reset = 1'b1;
  endtask

  task automatic waitDrain(input int maxCycles);
    logic drained;
    drained = 1'b0;
    for (int i = 0; i < maxCycles && !drained; i++) begin
      sampleCycle();
      drained = (q0.size() == 0) && (q1.size() == 0) && (grantQ.size() == 0) && !busy;
      nextCycle();
    end
    checkOutput("drain", drained, 1);
  endtask

  initial begin
    logic finished;
    checks      = 0;
    errors      = 0;
    done        = 2'b00;
    autoRelease = 2'b11;
    prevGrant   = 2'b00;
    reset       = 1'b0;
    applyStimulus(0, 1'b0, 1'b0, '0, '0);
    applyStimulus(1, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clock);
    #1;

    sampleCycle();
    checkOutput("reset grant", grant, 2'b00);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset mem read", memIf.readEnabled, 0);
    checkOutput("reset mem write", memIf.writeEnabled, 0);
    checkOutput("reset complete0", rq0.functionComplete, 0);
    checkOutput("reset complete1", rq1.functionComplete, 0);
    nextCycle();
    reset = 1'b1;

    $display("[TB] single read by requester0");
    applyStimulus(0, 1'b1, 1'b0, 5, 0);
    pushExpect(0, 1'b0, 32'hAB);
    grantQ.push_back(2'b01);
    for (int c = 0; c <= 5; c++) begin
      sampleCycle();
      checkOutput($sformatf("t1 grant c%0d", c), grant, (c >= 1 && c <= 4) ? 2'b01 : 2'b00);
      checkOutput($sformatf("t1 complete0 c%0d", c), rq0.functionComplete, (c == 4) ? 1 : 0);
      checkOutput($sformatf("t1 complete1 c%0d", c), rq1.functionComplete, 0);
      nextCycle();
    end
    waitDrain(10);

    $display("[TB] simultaneous requests after reset");
    doReset();
    applyStimulus(0, 1'b1, 1'b0, 5, 0);
    applyStimulus(1, 1'b1, 1'b0, 5, 0);
    pushExpect(0, 1'b0, 32'hAB);
    pushExpect(1, 1'b0, 32'hAB);
    grantQ.push_back(2'b01);
    grantQ.push_back(2'b10);
    for (int c = 0; c <= 6; c++) begin
      sampleCycle();
      checkOutput($sformatf("t2 grant c%0d", c), grant,
                  (c >= 1 && c <= 4) ? 2'b01 : (c == 6) ? 2'b10 : 2'b00);
      checkOutput($sformatf("t2 complete1 c%0d", c), rq1.functionComplete, 0);
      if (c == 5) begin
        checkOutput("t2 release busy", busy, 0);
        checkOutput("t2 release mem read", memIf.readEnabled, 0);
        checkOutput("t2 release mem write", memIf.writeEnabled, 0);
      end
      nextCycle();
    end
    waitDrain(20);

    $display("[TB] write by requester1 then read back by requester0");
    applyStimulus(1, 1'b0, 1'b1, 7, 32'h55);
    pushExpect(1, 1'b1, 0);
    grantQ.push_back(2'b10);
    waitDrain(20);
    applyStimulus(0, 1'b1, 1'b0, 7, 0);
    pushExpect(0, 1'b0, 32'h55);
    grantQ.push_back(2'b01);
    waitDrain(20);

    $display("[TB] continuous requests from both sides");
    doReset();
    autoRelease = 2'b00;
    applyStimulus(0, 1'b1, 1'b0, 5, 0);
    applyStimulus(1, 1'b1, 1'b0, 5, 0);
    for (int i = 0; i < 2; i++) begin
      pushExpect(0, 1'b0, 32'hAB);
      pushExpect(1, 1'b0, 32'hAB);
      grantQ.push_back(2'b01);
      grantQ.push_back(2'b10);
    end
    finished = 1'b0;
    for (int i = 0; i < 60 && !finished; i++) begin
      sampleCycle();
      finished = (q0.size() == 0) && (q1.size() == 0);
      nextCycle();
    end
    applyStimulus(0, 1'b0, 1'b0, 5, 0);
    applyStimulus(1, 1'b0, 1'b0, 5, 0);
    autoRelease = 2'b11;
    checkOutput("t4 four transactions", finished, 1);
    checkOutput("t4 grants left", grantQ.size(), 0);
    waitDrain(20);

    $display("[TB] reset during a write");
    applyStimulus(0, 1'b1, 1'b0, 5, 0);
    pushExpect(0, 1'b0, 32'hAB);
    grantQ.push_back(2'b01);
    waitDrain(20);
    applyStimulus(0, 1'b0, 1'b1, 9, 32'h77);
    grantQ.push_back(2'b01);
    runCycle();
    runCycle();
    reset = 1'b0;
    #1;
    checkOutput("t5 reset grant", grant, 2'b00);
    checkOutput("t5 reset busy", busy, 0);
    checkOutput("t5 reset mem read", memIf.readEnabled, 0);
    checkOutput("t5 reset mem write", memIf.writeEnabled, 0);
    checkOutput("t5 reset complete0", rq0.functionComplete, 0);
    applyStimulus(0, 1'b0, 1'b0, 9, 0);
    runCycle();
    reset = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 5, 0);
    applyStimulus(1, 1'b1, 1'b0, 5, 0);
    pushExpect(0, 1'b0, 32'hAB);
    pushExpect(1, 1'b0, 32'hAB);
    grantQ.push_back(2'b01);
    grantQ.push_back(2'b10);
    waitDrain(30);

    $display("[TB] abort by requester0 with requester1 pending");
    applyStimulus(0, 1'b1, 1'b0, 5, 0);
    grantQ.push_back(2'b01);
    runCycle();
    applyStimulus(1, 1'b1, 1'b0, 5, 0);
    pushExpect(1, 1'b0, 32'hAB);
    grantQ.push_back(2'b10);
    runCycle();
    applyStimulus(0, 1'b0, 1'b0, 5, 0);
    sampleCycle();
    checkOutput("t6 grant c2", grant, 2'b01);
    checkOutput("t6 mem read c2", memIf.readEnabled, 0);
    checkOutput("t6 complete0 c2", rq0.functionComplete, 0);
    nextCycle();
    sampleCycle();
    checkOutput("t6 release busy", busy, 0);
    checkOutput("t6 release grant", grant, 2'b00);
    checkOutput("t6 complete0 c3", rq0.functionComplete, 0);
    nextCycle();
    sampleCycle();
    checkOutput("t6 grant c4", grant, 2'b10);
    nextCycle();
    waitDrain(20);

    $display("[TB] request arriving in the completion cycle");
    applyStimulus(0, 1'b1, 1'b0, 7, 0);
    pushExpect(0, 1'b0, 32'h55);
    grantQ.push_back(2'b01);
    repeat (4) runCycle();
    applyStimulus(1, 1'b1, 1'b0, 5, 0);
    pushExpect(1, 1'b0, 32'hAB);
    grantQ.push_back(2'b10);
    sampleCycle();
    checkOutput("t7 grant c4", grant, 2'b01);
    checkOutput("t7 complete1 c4", rq1.functionComplete, 0);
    nextCycle();
    sampleCycle();
    checkOutput("t7 release grant", grant, 2'b00);
    nextCycle();
    sampleCycle();
    checkOutput("t7 grant c6", grant, 2'b10);
    nextCycle();
    waitDrain(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
